// File: rtl/shift_add_multiplier_if.sv
// Handshake and operand/result bundle for shift_add_multiplier.
// The in_R addend exists only when MUL_ADD_REM_EN is defined.
interface shift_add_multiplier_if #(
   parameter int unsigned WIDTH = 10
);
   logic               start;
   logic [WIDTH-1:0]   in_A;
   logic [WIDTH-1:0]   in_B;
`ifdef MUL_ADD_REM_EN
   logic [WIDTH-1:0]   in_R;
`endif
   logic               busy;
   logic               done;
   logic               ovf;
   logic [2*WIDTH-1:0] p_out;

   modport master (
      output start,
      output in_A,
      output in_B,
`ifdef MUL_ADD_REM_EN
      output in_R,
`endif
      input  busy,
      input  done,
      input  ovf,
      input  p_out
   );

   modport slave (
      input  start,
      input  in_A,
      input  in_B,
`ifdef MUL_ADD_REM_EN
      input  in_R,
`endif
      output busy,
      output done,
      output ovf,
      output p_out
   );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier, one iteration per clock: P = A*B.
// With MUL_ADD_REM_EN defined the accumulator starts at in_R, giving P = A*B + R.
module shift_add_multiplier #(
   parameter int unsigned WIDTH = 10
) (
   input  logic                   clk,
   input  logic                   sclr,
   shift_add_multiplier_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t               state_q;
   logic [WIDTH:0]       acc_q;
   logic [WIDTH-1:0]     q_q;
   logic [WIDTH-1:0]     b_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 ovf_q;
   logic [2*WIDTH-1:0]   p_q;

   logic [WIDTH:0]       sum_d;
   logic [WIDTH:0]       acc_d;
   logic [WIDTH-1:0]     q_d;
   logic [WIDTH:0]       acc_init;

`ifdef MUL_ADD_REM_EN
   assign acc_init = {1'b0, bus.in_R};
`else
   assign acc_init = '0;
`endif

   // Acc stays below 2^WIDTH after every shift, so the WIDTH+1 bit sum never wraps.
   always_comb begin
      sum_d = acc_q;
      if (q_q[0]) begin
         sum_d = acc_q + {1'b0, b_q};
      end
      acc_d = {1'b0, sum_d[WIDTH:1]};
      q_d   = {sum_d[0], q_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         q_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         p_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  b_q     <= bus.in_B;
                  q_q     <= bus.in_A;
                  acc_q   <= acc_init;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  p_q     <= '0;
                  ovf_q   <= 1'b0;
                  state_q <= S_CALC;
               end
            end
            S_CALC: begin
               acc_q <= acc_d;
               q_q   <= q_d;
               cnt_q <= cnt_q + CNT_W'(1);
               // Result registers load from the final iteration's next-state values.
               if (cnt_q == CNT_LAST) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  p_q     <= {acc_d[WIDTH-1:0], q_d};
                  ovf_q   <= |acc_d[WIDTH-1:0];
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.ovf   = ovf_q;
   assign bus.p_out = p_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: random and directed operands checked against A*B(+R).
// Define MUL_ADD_REM_EN for both RTL and bench to exercise the addend variant.
module tb_shift_add_multiplier;
   localparam int unsigned W = 10;

   typedef struct {
      longint unsigned p;
      bit              ovf;
      longint unsigned due;
   } exp_t;

   logic            clk = 1'b0;
   logic            sclr = 1'b1;
   longint unsigned cyc = 0;
   int              total = 0;
   int              bad = 0;
   exp_t            sb[$];

   shift_add_multiplier_if #(.WIDTH(W)) bus ();

   shift_add_multiplier #(.WIDTH(W)) dut (
      .clk  (clk),
      .sclr (sclr),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (!sclr && bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_done actual=1 required=0 at cycle %0d", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("p_out", 64'(bus.p_out), e.p);
            chk("ovf", 64'(bus.ovf), 64'(e.ovf));
            chk("latency", cyc, e.due);
            chk("busy_at_done", 64'(bus.busy), 64'd0);
         end
      end
   end

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] r, input longint unsigned due);
      exp_t e;
      e.p = longint'(a) * longint'(b);
`ifdef MUL_ADD_REM_EN
      e.p = e.p + longint'(r);
`endif
      e.ovf = (e.p >> W) != 0;
      e.due = due;
      return e;
   endfunction

   function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      v = W'($urandom);
      case ($urandom_range(0, 5))
         0: v = '0;
         1: v = '1;
         default: ;
      endcase
      return v;
   endfunction

   task automatic drive_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r);
      bus.in_A = a;
      bus.in_B = b;
`ifdef MUL_ADD_REM_EN
      bus.in_R = r;
`endif
   endtask

   task automatic drain(input string name);
      int guard = 0;
      while (sb.size() != 0 && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL %s_timeout actual=%0d pending required=0 pending", name, sb.size());
         sb.delete();
      end
   endtask

   // mode 0: plain, 1: start pulse during CALC, 2: sclr abort during CALC
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r,
                        input int mode);
      longint unsigned k;
      exp_t e;
      @(negedge clk);
      bus.start = 1'b1;
      drive_ops(a, b, r);
      @(posedge clk);
      #1;
      k = cyc;
      bus.start = 1'b0;
      drive_ops(W'($urandom), W'($urandom), W'($urandom));
      e = model(a, b, r, k + W);
      if (mode != 2) sb.push_back(e);
      if (mode == 1) begin
         repeat (3) @(negedge clk);
         chk("busy_in_calc", 64'(bus.busy), 64'd1);
         bus.start = 1'b1;
         drive_ops(5, 5, 5);
         @(negedge clk);
         bus.start = 1'b0;
      end
      if (mode == 2) begin
         repeat (5) @(negedge clk);
         sclr = 1'b1;
         @(negedge clk);
         sclr = 1'b0;
         chk("abort_busy", 64'(bus.busy), 64'd0);
         chk("abort_done", 64'(bus.done), 64'd0);
         chk("abort_p_out", 64'(bus.p_out), 64'd0);
         repeat (15) @(negedge clk);
      end else begin
         drain("done");
         @(negedge clk);
         chk("p_out_hold", 64'(bus.p_out), e.p);
         chk("done_pulse_end", 64'(bus.done), 64'd0);
      end
   endtask

   // start held high: accepts land every W+2 edges
   task automatic held(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r);
      longint unsigned k;
      @(negedge clk);
      bus.start = 1'b1;
      drive_ops(a, b, r);
      @(posedge clk);
      #1;
      k = cyc;
      for (int i = 0; i < 3; i++) sb.push_back(model(a, b, r, k + W + longint'(i) * (W + 2)));
      while (cyc < k + 2 * (W + 2) + 1) @(negedge clk);
      bus.start = 1'b0;
      drain("held");
      repeat (2) @(negedge clk);
   endtask

   initial begin
      bus.start = 1'b0;
      drive_ops('0, '0, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_ovf", 64'(bus.ovf), 64'd0);
      chk("rst_p_out", 64'(bus.p_out), 64'd0);
      sclr = 1'b0;

      issue(25, 12, 0, 0);
      issue(1023, 1023, 0, 0);
      issue(0, 77, 0, 0);
      issue(25, 12, 0, 1);
      issue(25, 12, 0, 2);
      issue(25, 12, 0, 0);
`ifdef MUL_ADD_REM_EN
      issue(7, 45, 3, 0);
      issue(1023, 1023, 1023, 0);
`endif
      held(31, 33, 9);
      for (int i = 0; i < 25; i++) issue(pick(), pick(), pick(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end
endmodule
